execute_stage_mfu: RTL and testbench
====================================

// Module: execute_stage_mfu
// PURPOSE
//  Parametrised execute stage. Executes one decoded uop at a time on the IntALU (1 cycle) or an
//  iterative multiplier (MUL_LATENCY cycles), forwarding from its own output register.
//  Sits between decode and writeback. Adds the following to the single-FU stage: correct rs1/rs2
//  bypass, x0 bypass suppression, a multi-cycle FU, and a synchronous flush.
// PARAMETERS
//  XLEN         32  datapath width; val_t is logic [XLEN-1:0]
//  MUL_LATENCY  3   cycles from MUL accept to registered result; legal range 1..8
//  ENABLE_MUL   1   0: FU_MUL is treated as an unknown FU (dropped) and mul_unit is not built
// PORTS
//  clk     in   1        clock, rising edge
//  rst     in   1        asynchronous, active-high reset
//  flush   in   1        synchronous kill of all in-flight work in this stage
//  u       pipeline_if.Upstream    u.valid in (uopIn valid); u.stall out
//  d       pipeline_if.Downstream  d.valid out (uopOut valid); d.stall in
//  uopIn   in   decode_t  decoded uop: fu, op, rs1/rs2, rs1val/rs2val, imm, immValid, rd, ex
//  uopOut  out  execute_t registered result: ex, rd, rdVal
// BEHAVIOUR
//  Reset (async): state=IDLE, hold buffer cleared, cnt=0, uopOut=0, d.valid=0, so u.stall=0.
//  u.stall = (state != IDLE). It is decoded from registered state only; there is no combinational path from d.stall.
//  Output register: while d.stall=1, uopOut and d.valid hold their values. They update only on edges with d.stall=0.
//  Current uop: the hold buffer in HOLD, otherwise uopIn qualified by u.valid.
//  Bypass, evaluated when the current uop executes:
//    s1 = (d.valid && rd!=0 && rs1==uopOut.rd) ? uopOut.rdVal : rs1val
//    s2 = immValid ? imm : (same test on rs2) ? uopOut.rdVal : rs2val
//  States:
//   IDLE: if u.valid:
//     - d.stall=1: capture uopIn into the hold buffer, go to HOLD.
//     - fu=FU_INTALU: uopOut <= {ex, rd, aluOut}, d.valid <= 1.
//     - fu=FU_MUL: latch s1, s2 and op into mul_unit. Set cnt=MUL_LATENCY-1. Go to MUL_BUSY.
//       d.valid <= 0 at this edge.
//     - other fu: uop consumed, d.valid <= 0.
//     If u.valid=0 and d.stall=0: d.valid <= 0.
//   HOLD: wait while d.stall=1. When d.stall=0, execute the held uop exactly as in IDLE
//     (bypass against the current uopOut). Go to IDLE, or to MUL_BUSY for FU_MUL.
//   MUL_BUSY:
//     - cnt!=0: cnt--.
//     - cnt==0 and d.stall=0: uopOut <= {ex, rd, mulResult}, d.valid <= 1, go to IDLE.
//     - cnt==0 and d.stall=1: stay in MUL_BUSY; the result is held inside mul_unit.
//  Timing: a MUL accepted at edge N has its result on uopOut after edge N+MUL_LATENCY
//    (with d.stall=0). The next uop is accepted at edge N+MUL_LATENCY+1.
//    ALU ops sustain one per cycle.
//  Multiply: a 2*XLEN product is formed. MUL returns the low XLEN bits.
//    MULH is signed*signed, MULHSU is signed*unsigned, MULHU is unsigned*unsigned; each returns
//    the high XLEN bits.
//  flush: sync, priority over all but rst. d.valid<=0, hold cleared, mul aborted, cnt=0, state=IDLE.
//    uopIn in that cycle is dropped. If flush=1 with d.stall=1, d.valid still clears.
//  rd==0 results are emitted normally (writeback discards them) but are never bypassed.
// STRUCTURE
//  Uop package gains: FU_MUL in the fu enum; mulop_t {MUL,MULH,MULHSU,MULHU}; a mul member
//  in the op union; and the stage state enum exe_state_t {IDLE,HOLD,MUL_BUSY}.
//  Sub-module mul_unit #(XLEN,MUL_LATENCY):
//    inputs: start, op, a, b, abort; output: result.
//    Latches operands on start and holds result until the next start.
//  IntALU is reused unchanged.
// TESTING
//  1 ALU chain: ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back
//    -> uopOut rd=2, rdVal=10 (rs1 and rs2 bypassed).
//  2 x0 bypass: ADDI x0,x0,7 then ADDI x3,x0,1 -> rdVal=1, not 8.
//  3 MUL, MUL_LATENCY=3: MUL x4 with s1=0xFFFFFFFF, s2=2 accepted at edge 0
//    -> d.valid=1 after edge 3, rdVal=0xFFFFFFFE; u.stall=1 over edges 1..3.
//    MULHU with the same operands -> 1; MULH -> 0xFFFFFFFF.
//  4 Downstream stall: d.stall=1 for 4 cycles while an ALU uop arrives
//    -> uopOut unchanged for 4 cycles, u.stall=1 from the next edge.
//    The held uop emerges one edge after d.stall drops, bypassing from the old uopOut.
//  5 Flush mid-MUL at cnt=1 -> d.valid=0, u.stall=0 next cycle, no MUL result is ever emitted.
//    A following ALU uop completes normally.
//  6 Async rst asserted mid-HOLD between clock edges -> d.valid=0 and u.stall=0 immediately.
//    An unknown fu with u.valid=1 -> consumed, d.valid=0.

Source files
------------

// File: rtl/execute_stage_mfu_pkg.sv
// execute_stage_mfu_pkg: uop, result and state types shared by the execute stage and its mul_unit
package execute_stage_mfu_pkg;
  localparam int DATA_W = 32;
  typedef logic [DATA_W-1:0] val_t;
  typedef logic [4:0] reg_t;
  typedef enum logic [1:0] {FU_INTALU, FU_MUL, FU_LSU, FU_BRU} fu_t;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } aluop_t;
  typedef enum logic [3:0] {MUL, MULH, MULHSU, MULHU} mulop_t;
  typedef union packed {
    aluop_t alu;
    mulop_t mul;
  } op_t;
  typedef struct packed {
    fu_t fu;
    op_t op;
    reg_t rs1;
    reg_t rs2;
    val_t rs1val;
    val_t rs2val;
    val_t imm;
    logic immValid;
    reg_t rd;
    logic ex;
  } decode_t;
  typedef struct packed {
    logic ex;
    reg_t rd;
    val_t rdVal;
  } execute_t;
  typedef enum logic [1:0] {IDLE, HOLD, MUL_BUSY} exe_state_t;
  function automatic val_t intAlu(aluop_t op, val_t a, val_t b);
    case (op)
      ALU_ADD:  intAlu = a + b;
      ALU_SUB:  intAlu = a - b;
      ALU_AND:  intAlu = a & b;
      ALU_OR:   intAlu = a | b;
      ALU_XOR:  intAlu = a ^ b;
      ALU_SLL:  intAlu = a << b[$clog2(DATA_W)-1:0];
      ALU_SRL:  intAlu = a >> b[$clog2(DATA_W)-1:0];
      ALU_SRA:  intAlu = val_t'($signed(a) >>> b[$clog2(DATA_W)-1:0]);
      ALU_SLT:  intAlu = val_t'($signed(a) < $signed(b));
      ALU_SLTU: intAlu = val_t'(a < b);
      default:  intAlu = '0;
    endcase
  endfunction
endpackage

// File: rtl/execute_stage_mfu_if.sv
// pipeline_if: valid/stall handshake between pipeline stages
// Upstream modport is the receiving side (valid in, stall out); Downstream is the sending side.
interface pipeline_if;
  logic valid;
  logic stall;
  modport Upstream(input valid, output stall);
  modport Downstream(output valid, input stall);
endinterface

// File: rtl/execute_stage_mfu_mul.sv
// mul_unit: latches operands on start and presents the selected half of the 2*XLEN product until the next start
// Ports: clk, rst (async), start (latch a/b/op), abort (clear), op, a, b -> result.
module mul_unit
  import execute_stage_mfu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int MUL_LATENCY = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  mulop_t          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);
  mulop_t opQ;
  logic [XLEN-1:0] aQ, bQ;
  logic [2*XLEN-1:0] aExt, bExt, prod;
  always_ff @(posedge clk or posedge rst)
    if (rst || abort) begin
      opQ <= MUL;
      aQ <= '0;
      bQ <= '0;
    end else if (start) begin
      opQ <= op;
      aQ <= a;
      bQ <= b;
    end
  always_comb begin
    assert (MUL_LATENCY >= 1 && MUL_LATENCY <= 8);
    aExt = {{XLEN{aQ[XLEN-1] && (opQ == MULH || opQ == MULHSU)}}, aQ};
    bExt = {{XLEN{bQ[XLEN-1] && opQ == MULH}}, bQ};
    prod = aExt * bExt;
    result = opQ == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end
endmodule

// File: rtl/execute_stage_mfu.sv
// execute_stage_mfu: execute stage with 1-cycle IntALU, multi-cycle multiplier, self-bypass and flush
// Ports: clk, rst (async, active high), flush (sync kill), u (upstream valid/stall),
//        d (downstream valid/stall), uopIn (decoded uop), uopOut (registered result).
module execute_stage_mfu
  import execute_stage_mfu_pkg::*;
#(
  parameter int XLEN = DATA_W,
  parameter int MUL_LATENCY = 3,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  pipeline_if.Upstream        u,
  pipeline_if.Downstream      d,
  input  decode_t             uopIn,
  output execute_t            uopOut
);
  exe_state_t state, stateNext;
  decode_t hold, cur;
  logic [2:0] cnt;
  reg_t mulRd;
  logic mulEx, dValid, goExec, isAlu, isMul, mulStart, mulDone;
  val_t s1, s2, aluOut, mulResult;
  assign u.stall = state != IDLE;
  assign d.valid = dValid;
  // x0 is never forwarded so a discarded write to x0 cannot leak into consumers.
  always_comb begin
    cur = state == HOLD ? hold : uopIn;
    s1 = dValid && uopOut.rd != '0 && cur.rs1 == uopOut.rd ? uopOut.rdVal : cur.rs1val;
    s2 = cur.immValid ? cur.imm : dValid && uopOut.rd != '0 && cur.rs2 == uopOut.rd ? uopOut.rdVal : cur.rs2val;
    aluOut = intAlu(cur.op.alu, s1, s2);
    goExec = !d.stall && (state == HOLD || (state == IDLE && u.valid));
    isAlu = cur.fu == FU_INTALU;
    isMul = ENABLE_MUL && cur.fu == FU_MUL;
    mulStart = goExec && isMul && !flush;
    mulDone = state == MUL_BUSY && cnt == '0 && !d.stall;
    stateNext = flush ? IDLE : goExec ? (isMul ? MUL_BUSY : IDLE) :
                state == IDLE && u.valid ? HOLD : mulDone ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= stateNext;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hold <= '0;
      cnt <= '0;
      uopOut <= '0;
      dValid <= 1'b0;
      mulRd <= '0;
      mulEx <= 1'b0;
    end else if (flush) begin
      hold <= '0;
      cnt <= '0;
      dValid <= 1'b0;
    end else begin
      if (state == IDLE && u.valid && d.stall) hold <= uopIn;
      if (goExec) begin
        dValid <= isAlu;
        if (isAlu) uopOut <= '{ex: cur.ex, rd: cur.rd, rdVal: aluOut};
        if (isMul) begin
          cnt <= 3'(MUL_LATENCY - 1);
          mulRd <= cur.rd;
          mulEx <= cur.ex;
        end
      end else if (mulDone) begin
        uopOut <= '{ex: mulEx, rd: mulRd, rdVal: mulResult};
        dValid <= 1'b1;
      end else if (state == IDLE && !d.stall) dValid <= 1'b0;
      if (state == MUL_BUSY && cnt != '0) cnt <= cnt - 3'd1;
    end
  generate
    if (ENABLE_MUL) begin : g_mul
      mul_unit #(.XLEN(XLEN), .MUL_LATENCY(MUL_LATENCY)) mulUnit (
        .clk(clk),
        .rst(rst),
        .start(mulStart),
        .abort(flush),
        .op(cur.op.mul),
        .a(s1),
        .b(s2),
        .result(mulResult)
      );
    end else begin : g_noMul
      assign mulResult = '0;
    end
  endgenerate
endmodule

// File: tb/tb_execute_stage_mfu.sv
// tb_execute_stage_mfu: directed vectors with hand-computed results for execute_stage_mfu
module tb_execute_stage_mfu;
  import execute_stage_mfu_pkg::*;
  logic clk = 1'b0, rst, flush;
  decode_t uopIn;
  execute_t uopOut;
  int vecs = 0, errs = 0;
  pipeline_if up();
  pipeline_if dn();
  execute_stage_mfu #(.MUL_LATENCY(3)) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .u(up),
    .d(dn),
    .uopIn(uopIn),
    .uopOut(uopOut)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic decode_t mk(input fu_t fu, input logic [3:0] op, input reg_t rd, input reg_t rs1,
                                 input reg_t rs2, input val_t v1, input val_t v2, input val_t imm,
                                 input logic iv);
    decode_t x;
    x = '0;
    x.fu = fu;
    x.op = op_t'(op);
    x.rd = rd;
    x.rs1 = rs1;
    x.rs2 = rs2;
    x.rs1val = v1;
    x.rs2val = v2;
    x.imm = imm;
    x.immValid = iv;
    return x;
  endfunction
  function automatic decode_t addi(input reg_t rd, input val_t imm);
    return mk(FU_INTALU, ALU_ADD, rd, 5'd0, 5'd0, 32'd0, 32'd0, imm, 1'b1);
  endfunction
  task automatic runMul(input string tag, input decode_t uop, input val_t exp);
    uopIn = uop;
    up.valid = 1'b1;
    tick;
    up.valid = 1'b0;
    repeat (3) tick;
    check({tag, "_valid"}, dn.valid, 1);
    check(tag, uopOut.rdVal, exp);
  endtask
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    up.valid = 1'b0;
    dn.stall = 1'b0;
    uopIn = '0;
    repeat (2) tick;
    rst = 1'b0;
    check("rst_dvalid", dn.valid, 0);
    check("rst_ustall", up.stall, 0);
    check("rst_uopout", uopOut, 0);
    uopIn = addi(5'd1, 32'd5);
    up.valid = 1'b1;
    tick;
    check("addi_x1_valid", dn.valid, 1);
    check("addi_x1", uopOut.rdVal, 5);
    uopIn = mk(FU_INTALU, ALU_ADD, 5'd2, 5'd1, 5'd1, 32'd99, 32'd99, 32'd0, 1'b0);
    tick;
    check("add_x2_rd", uopOut.rd, 2);
    check("add_x2_bypass", uopOut.rdVal, 10);
    uopIn = addi(5'd0, 32'd7);
    tick;
    check("addi_x0", uopOut.rdVal, 7);
    uopIn = addi(5'd3, 32'd1);
    tick;
    check("x0_no_bypass", uopOut.rdVal, 1);
    uopIn = mk(FU_MUL, MUL, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
    tick;
    up.valid = 1'b0;
    check("mul_e0_dvalid", dn.valid, 0);
    check("mul_e0_ustall", up.stall, 1);
    tick;
    check("mul_e1_ustall", up.stall, 1);
    tick;
    check("mul_e2_ustall", up.stall, 1);
    check("mul_e2_dvalid", dn.valid, 0);
    tick;
    check("mul_e3_dvalid", dn.valid, 1);
    check("mul_e3_rd", uopOut.rd, 4);
    check("mul_e3", uopOut.rdVal, 32'hFFFF_FFFE);
    check("mul_e3_ustall", up.stall, 0);
    runMul("mulhu", mk(FU_MUL, MULHU, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0), 32'd1);
    runMul("mulhsu", mk(FU_MUL, MULHSU, 5'd4, 5'd5, 5'd6, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0), 32'd1);
    runMul("mulh", mk(FU_MUL, MULH, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0), 32'hFFFF_FFFF);
    runMul("mul_bypass_imm", mk(FU_MUL, MUL, 5'd5, 5'd4, 5'd0, 32'd0, 32'd0, 32'd3, 1'b1), 32'hFFFF_FFFD);
    uopIn = addi(5'd6, 32'd3);
    up.valid = 1'b1;
    tick;
    check("addi_x6", uopOut.rdVal, 3);
    dn.stall = 1'b1;
    uopIn = mk(FU_INTALU, ALU_ADD, 5'd7, 5'd6, 5'd6, 32'd0, 32'd0, 32'd0, 1'b0);
    tick;
    up.valid = 1'b0;
    uopIn = '0;
    check("hold_ustall", up.stall, 1);
    check("hold_keep", uopOut.rdVal, 3);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("hold_keep_val", uopOut.rdVal, 3);
      check("hold_keep_dvalid", dn.valid, 1);
      check("hold_keep_ustall", up.stall, 1);
    end
    dn.stall = 1'b0;
    tick;
    check("hold_out_rd", uopOut.rd, 7);
    check("hold_out_bypass", uopOut.rdVal, 6);
    check("hold_out_ustall", up.stall, 0);
    uopIn = mk(FU_MUL, MUL, 5'd8, 5'd5, 5'd6, 32'd3, 32'd4, 32'd0, 1'b0);
    up.valid = 1'b1;
    tick;
    up.valid = 1'b0;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    check("flush_dvalid", dn.valid, 0);
    check("flush_ustall", up.stall, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("flush_no_mul", dn.valid, 0);
    end
    uopIn = addi(5'd9, 32'd9);
    up.valid = 1'b1;
    tick;
    check("post_flush_rd", uopOut.rd, 9);
    check("post_flush_alu", uopOut.rdVal, 9);
    dn.stall = 1'b1;
    flush = 1'b1;
    uopIn = addi(5'd10, 32'd11);
    tick;
    flush = 1'b0;
    check("flush_stall_dvalid", dn.valid, 0);
    check("flush_stall_ustall", up.stall, 0);
    dn.stall = 1'b0;
    up.valid = 1'b0;
    tick;
    check("flush_drop_uop", dn.valid, 0);
    uopIn = addi(5'd11, 32'd12);
    up.valid = 1'b1;
    tick;
    check("addi_x11", uopOut.rdVal, 12);
    dn.stall = 1'b1;
    uopIn = addi(5'd12, 32'd13);
    tick;
    up.valid = 1'b0;
    check("rst_hold_ustall_pre", up.stall, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dvalid", dn.valid, 0);
    check("async_rst_ustall", up.stall, 0);
    check("async_rst_uopout", uopOut, 0);
    tick;
    rst = 1'b0;
    dn.stall = 1'b0;
    uopIn = addi(5'd13, 32'd14);
    up.valid = 1'b1;
    tick;
    check("addi_x13", uopOut.rdVal, 14);
    uopIn = mk(FU_LSU, ALU_ADD, 5'd14, 5'd0, 5'd0, 32'd1, 32'd1, 32'd0, 1'b0);
    tick;
    up.valid = 1'b0;
    check("unknown_fu_dvalid", dn.valid, 0);
    check("unknown_fu_ustall", up.stall, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
